// File: rtl/dc_fu_dma_pkg.sv
// Shared definitions for the Fetch Unit DMA blocks.
// Contents: address-generator FSM state enum, AXI RRESP encodings,
//           and the burst-count width helper used by the address
//           generator and the handshake manager.
package dc_fu_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } addr_gen_state_e;

  localparam logic [1:0] RRESP_OKAY   = 2'd0;
  localparam logic [1:0] RRESP_EXOKAY = 2'd1;
  localparam logic [1:0] RRESP_SLVERR = 2'd2;
  localparam logic [1:0] RRESP_DECERR = 2'd3;

  // Number of bits needed to count full-or-partial bursts of a fetch.
  function automatic int unsigned burst_cnt_width(input int unsigned fetch_word_count_width,
                                                  input int unsigned max_burst_len);
    return fetch_word_count_width - max_burst_len;
  endfunction

endpackage

// File: rtl/dc_fu_dma_addr_gen.sv
// Burst address generator for the Fetch Unit DMA.
// Splits a fetch request (base address + beat count) into AXI read bursts,
// pulses start_fetch towards the handshake manager and advances
// axi_araddr/axi_arlen on every next_addr pulse it returns.
// Ports:
//   clk, rst (sync, active-high), en (global hold)
//   req_valid/req_base_addr/req_word_count : fetch request
//   busy, cfg_err, start_fetch, done        : status and pulses
//   trans_count                             : bursts still to issue
//   next_addr                               : current burst accepted
//   axi_araddr, axi_arlen                   : current burst
//   error_flag, fetch_err                   : RRESP in, sticky error out
module dc_fu_dma_addr_gen
  import dc_fu_dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH             = 32,
  parameter int unsigned FETCH_WORD_COUNT_WIDTH = 16,
  parameter int unsigned MAX_BURST_LEN          = 4,
  parameter int unsigned BYTES_PER_WORD_LOG2    = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  req_valid,
  input  logic [ADDR_WIDTH-1:0]                 req_base_addr,
  input  logic [FETCH_WORD_COUNT_WIDTH-1:0]     req_word_count,
  output logic                                  busy,
  output logic                                  cfg_err,
  output logic                                  start_fetch,
  output logic [burst_cnt_width(FETCH_WORD_COUNT_WIDTH, MAX_BURST_LEN)-1:0] trans_count,
  input  logic                                  next_addr,
  output logic [ADDR_WIDTH-1:0]                 axi_araddr,
  output logic [7:0]                            axi_arlen,
  input  logic [1:0]                            error_flag,
  output logic                                  fetch_err,
  output logic                                  done
);

  localparam int unsigned CNT_W   = burst_cnt_width(FETCH_WORD_COUNT_WIDTH, MAX_BURST_LEN);
  localparam int unsigned BB_LOG2 = MAX_BURST_LEN + BYTES_PER_WORD_LOG2;
  localparam logic [ADDR_WIDTH-1:0] BB_BYTES    = ADDR_WIDTH'(1) << BB_LOG2;
  localparam logic [7:0]            FULL_LEN_M1 = 8'((1 << MAX_BURST_LEN) - 1);

  addr_gen_state_e          state_q;
  logic [MAX_BURST_LEN-1:0] rem_q;
  logic                     after_fin_q;

  logic [CNT_W-1:0]         req_hi;
  logic [MAX_BURST_LEN-1:0] req_rem;
  logic [CNT_W-1:0]         req_cnt;
  logic                     req_bad;
  logic [CNT_W-1:0]         cnt_dec;

  // Only the final burst of a fetch with a remainder is short.
  function automatic logic [7:0] arlen_for(input logic [CNT_W-1:0]         cnt,
                                           input logic [MAX_BURST_LEN-1:0] rem);
    return (cnt == CNT_W'(1) && rem != '0) ? 8'(rem) - 8'd1 : FULL_LEN_M1;
  endfunction

  // Request decode and validation.
  always_comb begin
    req_hi  = req_word_count[FETCH_WORD_COUNT_WIDTH-1:MAX_BURST_LEN];
    req_rem = req_word_count[MAX_BURST_LEN-1:0];
    req_cnt = req_hi + CNT_W'(req_rem != '0);
    // An all-ones hi with a remainder would need one more burst than fits.
    req_bad = (req_word_count == '0) ||
              (req_base_addr[BB_LOG2-1:0] != '0) ||
              ((&req_hi) && (req_rem != '0));
    cnt_dec = trans_count - CNT_W'(1);
  end

  // FSM plus address/length/count arithmetic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      after_fin_q <= 1'b0;
      busy        <= 1'b0;
      cfg_err     <= 1'b0;
      start_fetch <= 1'b0;
      done        <= 1'b0;
      fetch_err   <= 1'b0;
      trans_count <= '0;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
    end else if (en) begin
      cfg_err     <= 1'b0;
      start_fetch <= 1'b0;
      done        <= 1'b0;
      // The manager's error flag lags by a cycle, so the first IDLE
      // cycle after FINISH still belongs to the finished fetch.
      after_fin_q <= (state_q == ST_FINISH);
      if (((state_q != ST_IDLE) || after_fin_q) && (error_flag != RRESP_OKAY)) begin
        fetch_err <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              cfg_err <= 1'b1;
            end else begin
              trans_count <= req_cnt;
              axi_araddr  <= req_base_addr;
              axi_arlen   <= arlen_for(req_cnt, req_rem);
              rem_q       <= req_rem;
              fetch_err   <= 1'b0;
              busy        <= 1'b1;
              start_fetch <= 1'b1;
              state_q     <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (next_addr) begin
            trans_count <= cnt_dec;
            axi_araddr  <= axi_araddr + BB_BYTES;
            axi_arlen   <= arlen_for(cnt_dec, rem_q);
            // trans_count hits zero on the same edge FINISH is entered.
            if (cnt_dec == '0) begin
              done    <= 1'b1;
              state_q <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
